// File: rtl/seg_decode_s_if.sv
// seg_decode_s_if: snoop bus between the 7-seg seconds display and its readback decoder
interface seg_decode_s_if;
  logic [13:0] seg;
  logic        seq_clr;
  logic [5:0]  cnt_s;
  logic        upd;
  logic        blank;
  logic        digit_err;
  logic        seq_err;
  modport master (output seg, seq_clr, input cnt_s, upd, blank, digit_err, seq_err);
  modport slave  (input seg, seq_clr, output cnt_s, upd, blank, digit_err, seq_err);
endinterface

// File: rtl/seg_decode_s.sv
// seg_decode_s: recovers 0..59 seconds from a two-digit active-low 7-seg bus with stability filter
module seg_decode_s #(
  parameter int STABLE_CYCLES = 4,
  parameter bit CHECK_SEQ     = 1
) (
  input logic           clk,
  input logic           rst,
  seg_decode_s_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic {SETTLE, LOCKED} state_t;
  state_t        state_q, state_d;
  logic [13:0]   seg_q;
  logic [CW-1:0] stab_q, stab_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          upd_q, upd_d, blank_q, blank_d, derr_q, derr_d, serr_q, serr_d, have_q, have_d;
  logic [4:0]    ones, tens;
  logic [5:0]    val, nxt;
  logic          same, commit, legal, seq_hit;
  // glyph lookup: {valid, digit}; abcdefg active-low
  function automatic logic [4:0] dec(input logic [6:0] g);
    case (g)
      7'b0000001: dec = 5'h10;
      7'b1001111: dec = 5'h11;
      7'b0010010: dec = 5'h12;
      7'b0000110: dec = 5'h13;
      7'b1001100: dec = 5'h14;
      7'b0100100: dec = 5'h15;
      7'b0100000: dec = 5'h16;
      7'b0001111: dec = 5'h17;
      7'b0000000: dec = 5'h18;
      7'b0000100: dec = 5'h19;
      default:    dec = 5'h00;
    endcase
  endfunction
  assign ones    = dec(bus.seg[6:0]);
  assign tens    = dec(bus.seg[13:7]);
  assign legal   = ones[4] & tens[4] & (tens[3:0] <= 4'd5);
  assign val     = 6'(tens[3:0]) * 6'd10 + 6'(ones[3:0]);
  assign nxt     = (cnt_q == 6'd59) ? 6'd0 : cnt_q + 6'd1;
  assign same    = bus.seg == seg_q;
  assign commit  = same && state_q == SETTLE && stab_q == CW'(STABLE_CYCLES - 1);
  assign seq_hit = CHECK_SEQ && have_q && val != cnt_q && val != nxt;
  // settle/lock sequencing and commit of the decoded value and flags
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    blank_d = blank_q;
    derr_d  = derr_q;
    have_d  = have_q;
    serr_d  = serr_q & ~bus.seq_clr;
    if (!same) begin
      state_d = SETTLE;
      stab_d  = '0;
    end else if (commit) begin
      state_d = LOCKED;
      if (legal) begin
        cnt_d   = val;
        upd_d   = val != cnt_q || !have_q;
        blank_d = 1'b0;
        derr_d  = 1'b0;
        have_d  = 1'b1;
        serr_d  = serr_d | seq_hit;
      end else begin
        blank_d = bus.seg == 14'h3FFF;
        derr_d  = bus.seg != 14'h3FFF;
        have_d  = 1'b0;
      end
    end else if (state_q == SETTLE) begin
      stab_d = stab_q + 1'b1;
    end
  end
  // state register; reset leaves the bus assumed blank so a blank input settles quietly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= 14'h3FFF;
      state_q <= SETTLE;
      stab_q  <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      blank_q <= 1'b1;
      derr_q  <= 1'b0;
      serr_q  <= 1'b0;
      have_q  <= 1'b0;
    end else begin
      seg_q   <= bus.seg;
      state_q <= state_d;
      stab_q  <= stab_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      blank_q <= blank_d;
      derr_q  <= derr_d;
      serr_q  <= serr_d;
      have_q  <= have_d;
    end
  end
  assign bus.cnt_s     = cnt_q;
  assign bus.upd       = upd_q;
  assign bus.blank     = blank_q;
  assign bus.digit_err = derr_q;
  assign bus.seq_err   = serr_q;
endmodule

// File: tb/tb_seg_decode_s.sv
// tb_seg_decode_s: run-length model of the seconds display decoder with directed vectors
module tb_seg_decode_s;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0, n_upd = 0, u0;
  logic [6:0] g[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic [13:0] m_last = 14'h3FFF;
  int m_run = 1, m_cnt = 0, m_o, m_t, m_v;
  bit m_upd = 0, m_blank = 1, m_derr = 0, m_serr = 0, m_have = 0, m_err;
  seg_decode_s_if bus ();
  seg_decode_s #(.STABLE_CYCLES(S), .CHECK_SEQ(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [13:0] pat(input int v);
    return {g[v / 10], g[v % 10]};
  endfunction
  // model: a pattern commits once it has been seen on S+1 consecutive edges
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last = 14'h3FFF; m_run = 1; m_cnt = 0; m_upd = 0;
      m_blank = 1; m_derr = 0; m_serr = 0; m_have = 0;
    end else begin
      m_upd = 0;
      m_err = 0;
      m_run = (bus.seg == m_last) ? m_run + 1 : 1;
      m_last = bus.seg;
      if (m_run == S + 1) begin
        m_o = -1;
        m_t = -1;
        for (int i = 0; i < 10; i++) begin
          if (g[i] == bus.seg[6:0]) m_o = i;
          if (g[i] == bus.seg[13:7]) m_t = i;
        end
        if (m_o >= 0 && m_t >= 0 && m_t <= 5) begin
          m_v = 10 * m_t + m_o;
          m_err = m_have && m_v != m_cnt && m_v != (m_cnt + 1) % 60;
          m_upd = m_v != m_cnt || !m_have;
          m_cnt = m_v; m_blank = 0; m_derr = 0; m_have = 1;
        end else if (bus.seg == 14'h3FFF) begin
          m_blank = 1; m_derr = 0; m_have = 0;
        end else begin
          m_blank = 0; m_derr = 1; m_have = 0;
        end
      end
      m_serr = m_err ? 1 : (bus.seq_clr ? 0 : m_serr);
    end
  end
  // compare DUT against the model shortly after every edge
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      chk("cnt_s", int'(bus.cnt_s), m_cnt);
      chk("upd", int'(bus.upd), int'(m_upd));
      chk("blank", int'(bus.blank), int'(m_blank));
      chk("digit_err", int'(bus.digit_err), int'(m_derr));
      chk("seq_err", int'(bus.seq_err), int'(m_serr));
      if (bus.upd) n_upd++;
    end
  end
  initial begin
    bus.seg = 14'h3FFF;
    bus.seq_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t1_blank", int'(bus.blank), 1);
    chk("t1_cnt", int'(bus.cnt_s), 0);
    chk("t1_nupd", n_upd, 0);
    chk("t1_derr", int'(bus.digit_err), 0);
    bus.seg = pat(3);
    repeat (4) @(negedge clk);
    chk("t2_upd_early", int'(bus.upd), 0);
    @(negedge clk);
    chk("t2_upd", int'(bus.upd), 1);
    chk("t2_cnt", int'(bus.cnt_s), 3);
    @(negedge clk);
    chk("t2_upd_once", int'(bus.upd), 0);
    repeat (4) @(negedge clk);
    chk("t2_nupd", n_upd, 1);
    bus.seg = pat(7);
    repeat (2) @(negedge clk);
    bus.seg = pat(3);
    repeat (8) @(negedge clk);
    chk("t3_nupd", n_upd, 1);
    chk("t3_cnt", int'(bus.cnt_s), 3);
    bus.seg = 14'h3FFF;
    repeat (6) @(negedge clk);
    chk("t4_blank", int'(bus.blank), 1);
    foreach (g[i]) if (i < 4) begin
      bus.seg = pat(i == 0 ? 58 : i == 1 ? 59 : i - 2);
      repeat (6) @(negedge clk);
    end
    chk("t4_nupd", n_upd, 5);
    chk("t4_serr", int'(bus.seq_err), 0);
    chk("t4_cnt", int'(bus.cnt_s), 1);
    bus.seg = pat(5);
    repeat (6) @(negedge clk);
    chk("t4_serr_set", int'(bus.seq_err), 1);
    repeat (4) @(negedge clk);
    chk("t4_serr_sticky", int'(bus.seq_err), 1);
    bus.seq_clr = 1'b1;
    @(negedge clk);
    bus.seq_clr = 1'b0;
    chk("t4_serr_clr", int'(bus.seq_err), 0);
    bus.seg = pat(9);
    repeat (4) @(negedge clk);
    bus.seq_clr = 1'b1;
    @(negedge clk);
    bus.seq_clr = 1'b0;
    chk("t4_err_wins", int'(bus.seq_err), 1);
    chk("t4_cnt9", int'(bus.cnt_s), 9);
    bus.seq_clr = 1'b1;
    @(negedge clk);
    bus.seq_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_serr_clr2", int'(bus.seq_err), 0);
    bus.seg = {g[6], g[0]};
    repeat (6) @(negedge clk);
    chk("t5_derr", int'(bus.digit_err), 1);
    chk("t5_cnt", int'(bus.cnt_s), 9);
    bus.seg = {7'h7F, g[4]};
    repeat (6) @(negedge clk);
    chk("t5_half_blank_derr", int'(bus.digit_err), 1);
    chk("t5_half_blank_blank", int'(bus.blank), 0);
    u0 = n_upd;
    bus.seg = pat(22);
    repeat (6) @(negedge clk);
    chk("t5_derr_clr", int'(bus.digit_err), 0);
    chk("t5_nupd", n_upd - u0, 1);
    chk("t5_serr", int'(bus.seq_err), 0);
    chk("t5_cnt", int'(bus.cnt_s), 22);
    bus.seg = pat(45);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_cnt", int'(bus.cnt_s), 0);
    chk("t6_rst_blank", int'(bus.blank), 1);
    chk("t6_rst_upd", int'(bus.upd), 0);
    chk("t6_rst_derr", int'(bus.digit_err), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_upd_early", int'(bus.upd), 0);
    @(negedge clk);
    chk("t6_upd", int'(bus.upd), 1);
    chk("t6_cnt", int'(bus.cnt_s), 45);
    chk("t6_serr", int'(bus.seq_err), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
